// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the memory-stage data memory.
//   - dm_op_e      : access-type encodings carried on DMOpM
//   - DM_WORDS_DEF : default RAM depth in 32-bit words
//   - DM_BE_W      : byte-enable width (lanes per word)
package dm_pkg;

    typedef enum logic [2:0] {
        DMOP_NONE = 3'd0,
        DMOP_W    = 3'd1,
        DMOP_HU   = 3'd2,
        DMOP_H    = 3'd3,
        DMOP_BU   = 3'd4,
        DMOP_B    = 3'd5
    } dm_op_e;

    localparam int DM_WORDS_DEF = 3072;
    localparam int DM_BE_W      = 4;

endpackage

// File: rtl/dm_load_ext.sv
// dm_load_ext: combinational load formatter.
//   word   in  32  selected memory word
//   offset in  2   byte offset within the word
//   op     in  3   access type (dm_op_e encoding; 6/7 treated as none)
//   data   out 32  addressed byte/half/word, sign- or zero-extended
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  op,
    output logic [31:0] data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
    end

    always_comb begin
        data = '0;
        case (op)
            DMOP_W:  data = word;
            DMOP_HU: data = {16'b0, half_sel};
            DMOP_H:  data = {{16{half_sel[15]}}, half_sel};
            DMOP_BU: data = {24'b0, byte_sel};
            DMOP_B:  data = {{24{byte_sel[7]}}, byte_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dm_stage.sv
// dm_stage: memory-stage data memory (word-organised RAM).
// Byte/half/word stores with lane enables, sign/zero-extending loads with
// zero-latency combinational read, misalignment and range flags.
//   clk        in  1   clock
//   reset      in  1   synchronous active-high; clears every word
//   AddrM      in  32  byte address
//   WDataM     in  32  store data
//   DMOpM      in  3   access type (dm_op_e)
//   DMWeM      in  1   store strobe
//   PCM        in  32  PC of the instruction in M (trace only)
//   DMRDM      out 32  extended load data (pre-write contents on a store)
//   AlignErrM  out 1   misaligned access
//   RangeErrM  out 1   address beyond the RAM
// Optional macro DM_TRACE_EN: print "@pc: *addr <= word" for every
// committed store (simulation only).
module dm_stage
    import dm_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEF,
    parameter int DM_AW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] AddrM,
    input  logic [31:0] WDataM,
    input  logic [2:0]  DMOpM,
    input  logic        DMWeM,
    input  logic [31:0] PCM,
    output logic [31:0] DMRDM,
    output logic        AlignErrM,
    output logic        RangeErrM
);

    logic [31:0]        mem [DM_WORDS];

    logic [DM_AW-1:0]   word_idx;
    logic [DM_AW-1:0]   acc_idx;
    logic [31:0]        word_idx_ext;
    logic [1:0]         offset;
    logic               upper_nz;
    logic               op_word;
    logic               op_half;
    logic               op_byte;
    logic               op_active;
    logic               align_err;
    logic               range_err;
    logic               valid;
    logic               wr_en;
    logic [31:0]        old_word;
    logic [31:0]        ext_data;
    logic [DM_BE_W-1:0] be;
    logic [31:0]        lane_data;
    logic [31:0]        merged_word;

    assign word_idx     = AddrM[DM_AW+1:2];
    assign word_idx_ext = 32'(word_idx);
    assign offset       = AddrM[1:0];
    assign upper_nz     = |AddrM[31:DM_AW+2];

    assign op_word   = (DMOpM == DMOP_W);
    assign op_half   = (DMOpM == DMOP_HU) || (DMOpM == DMOP_H);
    assign op_byte   = (DMOpM == DMOP_BU) || (DMOpM == DMOP_B);
    assign op_active = op_word || op_half || op_byte;

    assign align_err = (op_word && (offset != 2'd0)) || (op_half && offset[0]);
    assign range_err = op_active && (upper_nz || (word_idx_ext >= 32'(DM_WORDS)));
    assign valid     = op_active && !align_err && !range_err;

    assign AlignErrM = align_err;
    assign RangeErrM = range_err;

    // Keep the array index in bounds for out-of-range addresses; the result
    // is masked by valid anyway.
    assign acc_idx  = valid ? word_idx : '0;
    assign old_word = mem[acc_idx];

    dm_load_ext u_load_ext (
        .word   (old_word),
        .offset (offset),
        .op     (DMOpM),
        .data   (ext_data)
    );

    assign DMRDM = valid ? ext_data : 32'h0;

    always_comb begin
        be        = '0;
        lane_data = WDataM;
        if (op_word) begin
            be = 4'b1111;
        end else if (op_half) begin
            be        = offset[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{WDataM[15:0]}};
        end else if (op_byte) begin
            be        = 4'b0001 << offset;
            lane_data = {4{WDataM[7:0]}};
        end
    end

    generate
        for (genvar gi = 0; gi < DM_BE_W; gi++) begin : g_lane
            assign merged_word[gi*8 +: 8] = be[gi] ? lane_data[gi*8 +: 8]
                                                   : old_word[gi*8 +: 8];
        end
    endgenerate

    assign wr_en = DMWeM && valid;

    // Reset wins over a store presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[acc_idx] <= merged_word;
        end
    end

`ifdef DM_TRACE_EN
    logic [31:0] trace_word;

    // Full-word view of the merged result for the trace line.
    dm_load_ext u_trace_ext (
        .word   (merged_word),
        .offset (2'b00),
        .op     (DMOP_W),
        .data   (trace_word)
    );

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            $display("@%h: *%h <= %h", PCM, {AddrM[31:2], 2'b00}, trace_word);
        end
    end
`else
    logic pcm_unused;
    assign pcm_unused = ^PCM;
`endif

endmodule

// File: tb/tb_dm_stage.sv
module tb_dm_stage;

    logic        clk;
    logic        reset;
    logic [31:0] AddrM;
    logic [31:0] WDataM;
    logic [2:0]  DMOpM;
    logic        DMWeM;
    logic [31:0] PCM;
    logic [31:0] DMRDM;
    logic        AlignErrM;
    logic        RangeErrM;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        int          sel;   // 0 = DMRDM, 1 = AlignErrM, 2 = RangeErrM
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [int];

    dm_stage dut (
        .clk       (clk),
        .reset     (reset),
        .AddrM     (AddrM),
        .WDataM    (WDataM),
        .DMOpM     (DMOpM),
        .DMWeM     (DMWeM),
        .PCM       (PCM),
        .DMRDM     (DMRDM),
        .AlignErrM (AlignErrM),
        .RangeErrM (RangeErrM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] waddr);
        if (model_mem.exists(int'(waddr))) return model_mem[int'(waddr)];
        return 32'h0;
    endfunction

    // Independent reference: byte address range compare, shift-and-mask extract.
    function automatic void model_eval(input logic [2:0] op, input logic [31:0] addr,
                                       output logic [31:0] rd, output logic al,
                                       output logic rg, output logic ok);
        logic [31:0] w;
        logic [31:0] sh;
        w  = model_rd({addr[31:2], 2'b00});
        al = 1'b0;
        rg = 1'b0;
        rd = 32'h0;
        ok = 1'b0;
        if (op >= 3'd1 && op <= 3'd5) begin
            rg = (addr >= 32'h0000_3000);
            if (op == 3'd1) al = (addr[1:0] != 2'b00);
            if (op == 3'd2 || op == 3'd3) al = addr[0];
            ok = !al && !rg;
            if (ok) begin
                sh = w >> (8 * addr[1:0]);
                case (op)
                    3'd1: rd = w;
                    3'd2: rd = sh & 32'h0000_FFFF;
                    3'd3: rd = sh[15] ? (sh | 32'hFFFF_0000) : (sh & 32'h0000_FFFF);
                    3'd4: rd = sh & 32'h0000_00FF;
                    default: rd = sh[7] ? (sh | 32'hFFFF_FF00) : (sh & 32'h0000_00FF);
                endcase
            end
        end
    endfunction

    function automatic void model_store(input logic [2:0] op, input logic [31:0] addr,
                                        input logic [31:0] wd);
        logic [31:0] wa;
        logic [31:0] w;
        int          sh;
        wa = {addr[31:2], 2'b00};
        w  = model_rd(wa);
        sh = 8 * int'(addr[1:0]);
        if (op == 3'd1) w = wd;
        else if (op == 3'd2 || op == 3'd3)
            w = (w & ~(32'h0000_FFFF << sh)) | ((wd & 32'h0000_FFFF) << sh);
        else
            w = (w & ~(32'h0000_00FF << sh)) | ((wd & 32'h0000_00FF) << sh);
        model_mem[int'(wa)] = w;
    endfunction

    // One access: drive at negedge, push expectations, sample mid-low-phase,
    // then let the posedge commit and update the model.
    task automatic do_access(input string tag, input logic [2:0] op, input logic we,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic rst, input logic use_const,
                             input logic [31:0] const_rd);
        logic [31:0] e_rd;
        logic        e_al;
        logic        e_rg;
        logic        e_ok;
        exp_t        e;
        @(negedge clk);
        DMOpM  = op;
        DMWeM  = we;
        AddrM  = addr;
        WDataM = wd;
        reset  = rst;
        PCM    = PCM + 32'd4;
        model_eval(op, addr, e_rd, e_al, e_rg, e_ok);
        sb_q.push_back('{tag: {tag, ".rd"}, sel: 0, exp: e_rd});
        sb_q.push_back('{tag: {tag, ".al"}, sel: 1, exp: {31'b0, e_al}});
        sb_q.push_back('{tag: {tag, ".rg"}, sel: 2, exp: {31'b0, e_rg}});
        if (use_const) sb_q.push_back('{tag: {tag, ".const"}, sel: 0, exp: const_rd});
        #2;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                0:       check_val(e.tag, DMRDM, e.exp);
                1:       check_val(e.tag, {31'b0, AlignErrM}, e.exp);
                default: check_val(e.tag, {31'b0, RangeErrM}, e.exp);
            endcase
        end
        $display("txn %s op=%0d we=%0b rst=%0b addr=%h wd=%h rd=%h al=%0b rg=%0b",
                 tag, op, we, rst, addr, wd, DMRDM, AlignErrM, RangeErrM);
        @(posedge clk);
        if (rst) model_mem.delete();
        else if (we && e_ok) model_store(op, addr, wd);
        #1;
        reset = 1'b0;
        DMWeM = 1'b0;
        DMOpM = 3'd0;
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_addr;
        reset  = 1'b1;
        AddrM  = '0;
        WDataM = '0;
        DMOpM  = '0;
        DMWeM  = 1'b0;
        PCM    = 32'h0000_3000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        do_access("rst_ld0",    3'd1, 1'b0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h0);
        do_access("st_w4",      3'd1, 1'b1, 32'h4,    32'h12345678, 1'b0, 1'b1, 32'h0);
        do_access("ld_bu7",     3'd4, 1'b0, 32'h7,    32'h0,        1'b0, 1'b1, 32'h12);
        do_access("ld_h6",      3'd3, 1'b0, 32'h6,    32'h0,        1'b0, 1'b1, 32'h1234);
        do_access("st_b9",      3'd5, 1'b1, 32'h9,    32'hFF,       1'b0, 1'b1, 32'h0);
        do_access("ld_b9",      3'd5, 1'b0, 32'h9,    32'h0,        1'b0, 1'b1, 32'hFFFF_FFFF);
        do_access("ld_w8",      3'd1, 1'b0, 32'h8,    32'h0,        1'b0, 1'b1, 32'h0000_FF00);
        do_access("st_h3_mis",  3'd2, 1'b1, 32'h3,    32'hBEEF,     1'b0, 1'b1, 32'h0);
        do_access("ld_w0",      3'd1, 1'b0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h0);
        do_access("st_w3000",   3'd1, 1'b1, 32'h3000, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0);
        do_access("ld_w2ffc",   3'd1, 1'b0, 32'h2FFC, 32'h0,        1'b0, 1'b1, 32'h0);
        do_access("st_hi_rng",  3'd1, 1'b1, 32'h8000_0004, 32'h1,   1'b0, 1'b1, 32'h0);
        do_access("ld_w4_keep", 3'd1, 1'b0, 32'h4,    32'h0,        1'b0, 1'b1, 32'h12345678);
        do_access("st_w2ffc",   3'd1, 1'b1, 32'h2FFC, 32'hCAFEF00D, 1'b0, 1'b1, 32'h0);
        do_access("ld_hu2ffe",  3'd2, 1'b0, 32'h2FFE, 32'h0,        1'b0, 1'b1, 32'h0000_CAFE);
        do_access("st_b20",     3'd4, 1'b1, 32'h20,   32'h11,       1'b0, 1'b0, 32'h0);
        do_access("st_b21",     3'd4, 1'b1, 32'h21,   32'h22,       1'b0, 1'b1, 32'h0);
        do_access("ld_w20",     3'd1, 1'b0, 32'h20,   32'h0,        1'b0, 1'b1, 32'h0000_2211);
        do_access("st_h_upper", 3'd2, 1'b1, 32'h22,   32'h8001,     1'b0, 1'b0, 32'h0);
        do_access("ld_h22",     3'd3, 1'b0, 32'h22,   32'h0,        1'b0, 1'b1, 32'hFFFF_8001);
        do_access("op7_none",   3'd7, 1'b1, 32'h3,    32'h5,        1'b0, 1'b1, 32'h0);
        do_access("st_w10_rst", 3'd1, 1'b1, 32'h10,   32'hAAAAAAAA, 1'b1, 1'b0, 32'h0);
        do_access("ld_w10",     3'd1, 1'b0, 32'h10,   32'h0,        1'b0, 1'b1, 32'h0);
        do_access("ld_w4_clr",  3'd1, 1'b0, 32'h4,    32'h0,        1'b0, 1'b1, 32'h0);

        for (int i = 0; i < 60; i++) begin
            r_op   = 3'($urandom_range(0, 7));
            r_addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(32'h2FF0, 32'h300F))
                                                 : 32'($urandom_range(0, 63));
            do_access($sformatf("rnd%0d", i), r_op, 1'($urandom_range(0, 1)), r_addr,
                      $urandom(), 1'b0, 1'b0, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_stage.md
# dm_stage

Memory-stage data memory of the five-stage pipeline: a word-organised RAM with byte/halfword/word stores and sign- or zero-extending loads. It sits between the execute/memory pipeline register and the memory/writeback pipeline register. Its load result is registered into the writeback stage alongside the ALU result, destination register and PC+8. It also flags misaligned and out-of-range accesses.

## Interface
- DM_WORDS, 3072: number of 32-bit words (byte range 0x0000–0x2FFF).
- DM_AW, 12: word-index width; must satisfy 2^DM_AW ≥ DM_WORDS.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- AddrM  in  32  byte address (ALU result).
- WDataM  in  32  store data (forwarded rt value).
- DMOpM  in  3  access type: 0 none, 1 word, 2 half-unsigned, 3 half-signed, 4 byte-unsigned, 5 byte-signed; 6/7 behave as 0.
- DMWeM  in  1  store strobe; loads are DMWeM=0 with a nonzero DMOpM.
- PCM  in  32  PC of the instruction in M, used only for the trace.
- DMRDM  out  32  extended load data.
- AlignErrM  out  1  misaligned access.
- RangeErrM  out  1  word index ≥ DM_WORDS.

## Operation
- Word index = AddrM[DM_AW+1:2]; byte offset = AddrM[1:0]. AddrM bits above DM_AW+1 that are nonzero count as out of range.
- Alignment rules:
  - Word: offset must be 0.
  - Half: AddrM[0] must be 0.
  - Byte: always aligned.
  - DMOpM of none never errors.
- An access is valid when DMOpM ≠ none, it is aligned, and it is in range.
- Store (DMWeM=1 and valid): byte enables come from type and offset.
  - Word: enables 1111.
  - Half: 0011 at offset 0, 1100 at offset 2.
  - Byte: one-hot at the offset.
  - Lane data is WDataM[7:0] for a byte and WDataM[15:0] for a half, replicated into the enabled lanes. Other lanes are unchanged.
- Store with an invalid access: no write, and the error flag asserts.
- Load: select the word, take the addressed byte or half, then sign- or zero-extend per DMOpM.
  - Invalid access gives DMRDM = 0.
  - DMOpM = none gives DMRDM = 0.
- A store also drives DMRDM, computed as a load of the same width on the pre-write contents.

## Timing
- Read is combinational with zero latency. During a cycle with a write, DMRDM shows the old contents; the new contents are visible from the next cycle.
- Write commits at posedge clk.
- reset has priority over a write in the same cycle. On the reset edge, every word clears to 0.
- Reset values of the outputs:
  - DMRDM = 0 for any load after reset.
  - AlignErrM and RangeErrM are combinational from the inputs. They are 0 when DMOpM = none.
- Back-to-back stores to the same word in consecutive cycles both commit in order; the second merges with the first's result.
- Reset held mid-stream discards any store presented in that cycle.
- Error flags are valid in the same cycle as the access. The block does not latch them.

## Configuration
- DM_TRACE_EN defined: every committed store prints "@%h: *%h <= %h" with PCM, the word-aligned byte address, and the full merged word after the write. Uses $display at the clock edge and is simulation-only.
- DM_TRACE_EN undefined: no display statements and identical functional behaviour.

## Structure
- Shared package dm_pkg holds:
  - DMOp encodings (DMOP_NONE, DMOP_W, DMOP_HU, DMOP_H, DMOP_BU, DMOP_B).
  - DM_WORDS_DEF.
  - The byte-enable width constant.
- One sub-module, dm_load_ext: purely combinational. Inputs are the word, offset and DMOpM; output is the extended 32-bit value. Both the load path and the trace merge path reuse it.

## Test plan
- Reset, then load word at 0x0 → DMRDM=0, both error flags 0.
- Store word 0x12345678 at 0x4, then load byte-unsigned at 0x7 → 0x12. Load half-signed at 0x6 → 0x1234.
- Store byte 0xFF at 0x9 on a zeroed word, then load byte-signed at 0x9 → 0xFFFFFFFF. Load word at 0x8 → 0x0000FF00.
- Store half 0xBEEF at 0x3 → AlignErrM=1 in that cycle, no write. Then load word at 0x0 → unchanged.
- Store word at 0x3000 (DM_WORDS=3072) → RangeErrM=1, DMRDM=0, no memory word changes.
- Store word 0xAAAAAAAA at 0x10 with reset=1 in the same cycle → word reads 0 afterwards. With DM_TRACE_EN, no trace line is printed.
